load_store_unit: RTL and testbench
==================================

# load_store_unit

Sequential, parametrised load/store unit replacing the single-cycle combinational memory access path in the execute stage. Accepts one RV32I load or store per handshake, computes the effective address, drives a variable-latency data-memory bus with byte enables, and returns sign/zero-extended load data or a store completion. Adds misalignment and address-range checking and a bus timeout, none of which the combinational path provides.

## Interface
Parameters:
- ADDR_WIDTH, 16, implemented byte-address bits; legal range 8..32
- TIMEOUT_CYCLES, 15, REQ-state cycles without mem_ack before a fault; legal range 1..255

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu (bu/hu are loads only)
- req_base  in  32  rs1 value
- req_offset  in  12  I- or S-type immediate, sign-extended internally
- req_wdata  in  32  rs2 value (stores)
- req_rd  in  5  destination register tag
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_data  out  32  extended load data; 0 for stores and errors
- rsp_rd  out  5  tag of the request
- rsp_misaligned  out  1  address misaligned for access size
- rsp_fault  out  1  illegal funct3, out-of-range address or timeout
- mem_req  out  1  bus request, held until ack
- mem_we  out  1  write
- mem_addr  out  ADDR_WIDTH  word-aligned byte address (bits [1:0] = 0)
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated write data
- mem_ack  in  1  bus completion; ignored outside REQ
- mem_rdata  in  32  read word, valid with mem_ack

## Operation
- States: IDLE, REQ, RESP. Reset value of every output is 0 except req_ready = 1; state = IDLE, timeout counter = 0.
- IDLE: on req_valid && req_ready, latch all request fields; ea = req_base + sext(req_offset), 32-bit wrap.
- Checks at accept, in priority order: illegal funct3 (011, 110, 111, or store with 100/101) -> fault; ea[31:ADDR_WIDTH] != 0 -> fault; h/hu with ea[0] = 1 or w with ea[1:0] != 0 -> misaligned. Any check hit -> RESP with no bus access.
- Otherwise -> REQ. mem_addr = {ea[ADDR_WIDTH-1:2], 2'b00}, lane = ea[1:0].
- Store byte: mem_be = 1 << lane, mem_wdata = {4{wdata[7:0]}}. Halfword: mem_be = 0011 (lane 0) or 1100 (lane 2), mem_wdata = {2{wdata[15:0]}}. Word: 1111, wdata. Loads: mem_be = 1111, mem_wdata = 0.
- REQ: mem_req = 1, all mem_* stable until mem_ack. On mem_ack -> RESP; for loads extract lane byte/halfword from mem_rdata, sign-extend (b, h) or zero-extend (bu, hu).
- Timeout: counter increments each REQ cycle without ack; on reaching TIMEOUT_CYCLES, drop mem_req, rsp_fault = 1, -> RESP. Ack in the same cycle the limit is reached wins (normal completion).
- RESP: rsp_valid = 1, rsp_* stable until rsp_ready; on rsp_ready -> IDLE. Flags and rsp_data cleared on leaving RESP.
- rd = 0 loads still access memory; writeback discards.

## Timing
- Accept at edge N; mem_req high in cycle N+1; ack in cycle N+1 gives rsp_valid in N+2 (minimum load/store latency 2).
- Error-check responses: rsp_valid in N+1, mem_req never asserted.
- New request accepted at earliest the cycle after the rsp_valid && rsp_ready cycle; no overlap, one outstanding access.
- Timeout: mem_req high exactly TIMEOUT_CYCLES cycles, rsp_valid the following cycle.
- rst_n low at any time: all outputs to reset values asynchronously, mem_req drops immediately, in-flight access abandoned without response.

## Test plan
- Store byte: base 0x100, offset 0x003, wdata 0x000000A5, funct3 000 -> mem_addr 0x100, mem_be 1000, mem_wdata 0xA5A5A5A5, mem_we 1; ack next cycle -> rsp_valid, rsp_data 0, flags 0.
- Load sign/zero: mem_rdata 0x80FF7F01; lb at 0x201 -> 0x0000007F; lb at 0x202 -> 0xFFFFFFFF; lhu at 0x202 -> 0x000080FF; lh at 0x202 -> 0xFFFF80FF.
- Misaligned/illegal: lw at 0x102 -> rsp_misaligned 1 in N+1, no mem_req; store funct3 100 -> rsp_fault 1; base 0x00010000 with ADDR_WIDTH 16 -> rsp_fault 1.
- Offset wrap: base 0x00000004, offset 0xFFC, lw -> mem_addr 0x0000; ack 3 cycles late -> mem_* held stable, rsp after ack.
- Timeout and backpressure: never ack -> mem_req high 15 cycles, rsp_fault 1; hold rsp_ready 0 for 4 cycles -> rsp_* stable, req_ready 0.
- Reset mid-REQ: drop rst_n during REQ -> mem_req 0 and req_ready 1 immediately, no rsp_valid after release.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
//   Sequential RV32I load/store unit. Accepts one load or store per
//   req_valid/req_ready handshake, forms the effective address, runs a single
//   access on a variable-latency word bus and returns extended load data or a
//   store completion on the rsp_* handshake. Illegal funct3 and out-of-range
//   addresses raise rsp_fault, misaligned accesses raise rsp_misaligned
//   (neither touches the bus), and a bus that never acks raises rsp_fault
//   after TIMEOUT_CYCLES.
// Ports:
//   clk, rst_n                : clock (rising edge), async active-low reset
//   req_*                     : request handshake and fields
//   rsp_*                     : response handshake, data and status flags
//   mem_req/we/addr/be/wdata  : data-memory bus request, held until mem_ack
//   mem_ack, mem_rdata        : bus completion and read word
module load_store_unit #(
   parameter int unsigned ADDR_WIDTH     = 16,
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_store,
   input  logic [2:0]            req_funct3,
   input  logic [31:0]           req_base,
   input  logic [11:0]           req_offset,
   input  logic [31:0]           req_wdata,
   input  logic [4:0]            req_rd,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_data,
   output logic [4:0]            rsp_rd,
   output logic                  rsp_misaligned,
   output logic                  rsp_fault,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [3:0]            mem_be,
   output logic [31:0]           mem_wdata,
   input  logic                  mem_ack,
   input  logic [31:0]           mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

   state_t                state_q, state_d;
   logic                  store_q, store_d;
   logic [2:0]            funct3_q, funct3_d;
   logic [4:0]            rd_q, rd_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [1:0]            lane_q, lane_d;
   logic [3:0]            be_q, be_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [31:0]           data_q, data_d;
   logic                  mis_q, mis_d;
   logic                  fault_q, fault_d;

   logic [31:0] ea;
   logic        illegal, out_of_range, misaligned;
   logic [3:0]  st_be;
   logic [31:0] st_wdata;
   logic [31:0] lane_word;
   logic [31:0] ld_data;

   always_comb begin
      ea = req_base + {{20{req_offset[11]}}, req_offset};

      illegal = 1'b0;
      case (req_funct3)
         3'b011, 3'b110, 3'b111: illegal = 1'b1;
         3'b100, 3'b101:         illegal = req_store;
         default:                illegal = 1'b0;
      endcase

      // Shift form stays legal when ADDR_WIDTH is 32 (empty upper slice).
      out_of_range = (ea >> ADDR_WIDTH) != '0;
      misaligned   = ((req_funct3[1:0] == 2'b01) && ea[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (ea[1:0] != 2'b00));

      st_be    = 4'b1111;
      st_wdata = req_wdata;
      case (req_funct3[1:0])
         2'b00: begin
            st_be    = 4'b0001 << ea[1:0];
            st_wdata = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            st_be    = ea[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{req_wdata[15:0]}};
         end
         default: begin
            st_be    = 4'b1111;
            st_wdata = req_wdata;
         end
      endcase

      lane_word = mem_rdata >> {lane_q, 3'b000};
      case (funct3_q)
         3'b000:  ld_data = {{24{lane_word[7]}}, lane_word[7:0]};
         3'b001:  ld_data = {{16{lane_word[15]}}, lane_word[15:0]};
         3'b100:  ld_data = {24'd0, lane_word[7:0]};
         3'b101:  ld_data = {16'd0, lane_word[15:0]};
         default: ld_data = mem_rdata;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      store_d  = store_q;
      funct3_d = funct3_q;
      rd_d     = rd_q;
      addr_d   = addr_q;
      lane_d   = lane_q;
      be_d     = be_q;
      wdata_d  = wdata_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
      mis_d    = mis_q;
      fault_d  = fault_q;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               store_d  = req_store;
               funct3_d = req_funct3;
               rd_d     = req_rd;
               addr_d   = {ea[ADDR_WIDTH-1:2], 2'b00};
               lane_d   = ea[1:0];
               be_d     = req_store ? st_be : 4'b1111;
               wdata_d  = req_store ? st_wdata : '0;
               cnt_d    = '0;
               if (illegal || out_of_range) begin
                  fault_d = 1'b1;
                  state_d = S_RESP;
               end else if (misaligned) begin
                  mis_d   = 1'b1;
                  state_d = S_RESP;
               end else begin
                  state_d = S_REQ;
               end
            end
         end
         S_REQ: begin
            // An ack arriving on the limit cycle still completes normally.
            if (mem_ack) begin
               data_d  = store_q ? '0 : ld_data;
               cnt_d   = '0;
               state_d = S_RESP;
            end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
               fault_d = 1'b1;
               cnt_d   = '0;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               data_d  = '0;
               mis_d   = 1'b0;
               fault_d = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         store_q  <= 1'b0;
         funct3_q <= '0;
         rd_q     <= '0;
         addr_q   <= '0;
         lane_q   <= '0;
         be_q     <= '0;
         wdata_q  <= '0;
         cnt_q    <= '0;
         data_q   <= '0;
         mis_q    <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         store_q  <= store_d;
         funct3_q <= funct3_d;
         rd_q     <= rd_d;
         addr_q   <= addr_d;
         lane_q   <= lane_d;
         be_q     <= be_d;
         wdata_q  <= wdata_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         mis_q    <= mis_d;
         fault_q  <= fault_d;
      end
   end

   // Bus fields are forced to zero outside REQ so they read as idle.
   always_comb begin
      req_ready      = (state_q == S_IDLE);
      rsp_valid      = (state_q == S_RESP);
      rsp_data       = data_q;
      rsp_rd         = rd_q;
      rsp_misaligned = mis_q;
      rsp_fault      = fault_q;
      mem_req        = (state_q == S_REQ);
      mem_we         = mem_req && store_q;
      mem_addr       = mem_req ? addr_q : '0;
      mem_be         = mem_req ? be_q : '0;
      mem_wdata      = mem_req ? wdata_q : '0;
   end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

   localparam int AW = 16;
   localparam int TO = 15;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_store = 1'b0;
   logic [2:0]    req_funct3 = '0;
   logic [31:0]   req_base = '0;
   logic [11:0]   req_offset = '0;
   logic [31:0]   req_wdata = '0;
   logic [4:0]    req_rd = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [31:0]   rsp_data;
   logic [4:0]    rsp_rd;
   logic          rsp_misaligned;
   logic          rsp_fault;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [3:0]    mem_be;
   logic [31:0]   mem_wdata;
   logic          mem_ack = 1'b0;
   logic [31:0]   mem_rdata = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   load_store_unit #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
      .req_funct3(req_funct3), .req_base(req_base), .req_offset(req_offset),
      .req_wdata(req_wdata), .req_rd(req_rd),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_rd(rsp_rd), .rsp_misaligned(rsp_misaligned), .rsp_fault(rsp_fault),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   // kind: 0 bus access completes, 1 misaligned, 2 fault at accept, 3 timeout
   typedef struct {
      logic        store;
      logic [2:0]  f3;
      logic [31:0] base;
      logic [11:0] off;
      logic [31:0] wdata;
      logic [4:0]  rd;
      int          delay;
      logic [31:0] rdata;
      int          hold;
      int          kind;
      logic [15:0] addr;
      logic [3:0]  be;
      logic [31:0] mwdata;
      logic [31:0] data;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(logic store, logic [2:0] f3, logic [31:0] base, logic [11:0] off,
                               logic [31:0] wdata, int delay, logic [31:0] rdata, int hold,
                               int kind, logic [15:0] addr, logic [3:0] be,
                               logic [31:0] mwdata, logic [31:0] data);
      vec_t v;
      v.store = store; v.f3 = f3; v.base = base; v.off = off; v.wdata = wdata;
      v.rd = 5'(($urandom % 31) + 1); v.delay = delay; v.rdata = rdata; v.hold = hold;
      v.kind = kind; v.addr = addr; v.be = be; v.mwdata = mwdata; v.data = data;
      return v;
   endfunction

   // Reference model: expectations from the architectural rules.
   function automatic vec_t model(vec_t v);
      logic [31:0] ea;
      longint      size, lane, val;
      logic        illegal, oor;
      ea      = v.base + 32'($signed(v.off));
      illegal = (v.f3 == 3) || (v.f3 >= 6) || (v.store && v.f3 >= 4);
      oor     = longint'(ea) > ((longint'(1) << AW) - 1);
      size    = longint'(1) << v.f3[1:0];
      lane    = longint'(ea) % 4;
      v.addr = 16'(ea - 32'(lane));
      v.be = v.store ? 4'(((longint'(1) << size) - 1) << lane) : 4'hF;
      if (!v.store)              v.mwdata = 0;
      else if (size == 1)        v.mwdata = 32'(longint'(v.wdata[7:0]) * 64'h01010101);
      else if (size == 2)        v.mwdata = 32'(longint'(v.wdata[15:0]) * 64'h00010001);
      else                       v.mwdata = v.wdata;
      v.data = 0;
      if (illegal || oor)               v.kind = 2;
      else if (longint'(ea) % size != 0) v.kind = 1;
      else if (v.delay >= TO)           v.kind = 3;
      else begin
         v.kind = 0;
         if (!v.store) begin
            val = (longint'(v.rdata) >> (8 * lane)) % (longint'(1) << (8 * size));
            if (!v.f3[2] && size < 4 && val >= (longint'(1) << (8 * size - 1)))
               val = val - (longint'(1) << (8 * size));
            v.data = 32'(val);
         end
      end
      return v;
   endfunction

   task automatic check_rsp(input vec_t v, input string tag);
      chk({tag, ".rsp_valid"}, 32'(rsp_valid), 1);
      chk({tag, ".req_ready"}, 32'(req_ready), 0);
      chk({tag, ".rsp_data"}, rsp_data, v.data);
      chk({tag, ".rsp_rd"}, 32'(rsp_rd), 32'(v.rd));
      chk({tag, ".rsp_mis"}, 32'(rsp_misaligned), 32'(v.kind == 1));
      chk({tag, ".rsp_fault"}, 32'(rsp_fault), 32'(v.kind >= 2));
   endtask

   // Entered and left at a negedge with the unit idle.
   task automatic run(input vec_t v, input string tag);
      int n;
      chk({tag, ".idle_ready"}, 32'(req_ready), 1);
      req_valid = 1; req_store = v.store; req_funct3 = v.f3; req_base = v.base;
      req_offset = v.off; req_wdata = v.wdata; req_rd = v.rd;
      @(posedge clk); #1;
      req_valid = 0; req_base = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
      @(negedge clk);
      if (v.kind == 1 || v.kind == 2) begin
         chk({tag, ".no_mem_req"}, 32'(mem_req), 0);
      end else begin
         n = 0;
         while (mem_req && n < 300) begin
            chk({tag, ".mem_we"}, 32'(mem_we), 32'(v.store));
            chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(v.addr));
            chk({tag, ".mem_be"}, 32'(mem_be), 32'(v.be));
            chk({tag, ".mem_wdata"}, mem_wdata, v.mwdata);
            mem_rdata = $urandom;
            if (n == v.delay) begin
               mem_ack = 1; mem_rdata = v.rdata;
            end
            @(posedge clk); #1;
            mem_ack = 0; mem_rdata = $urandom;
            @(negedge clk);
            n++;
         end
         chk({tag, ".req_cycles"}, 32'(n), (v.kind == 3) ? TO : v.delay + 1);
         chk({tag, ".mem_req_off"}, 32'(mem_req), 0);
      end
      check_rsp(v, tag);
      repeat (v.hold) begin
         @(negedge clk);
         check_rsp(v, {tag, ".hold"});
      end
      rsp_ready = 1;
      @(posedge clk); #1;
      rsp_ready = 0;
      @(negedge clk);
      chk({tag, ".rsp_done"}, 32'(rsp_valid), 0);
      chk({tag, ".ready_again"}, 32'(req_ready), 1);
      chk({tag, ".flags_clr"}, {rsp_data[29:0], rsp_misaligned, rsp_fault}, 0);
   endtask

   vec_t tbl[13];
   vec_t rv;

   initial begin
      tbl[0]  = mk(1, 3'b000, 32'h100,   12'h003, 32'h000000A5, 0, 0,            0, 0, 16'h0100, 4'b1000, 32'hA5A5A5A5, 0);
      tbl[1]  = mk(0, 3'b000, 32'h200,   12'h001, 0,            0, 32'h80FF7F01, 0, 0, 16'h0200, 4'hF,    0, 32'h0000007F);
      tbl[2]  = mk(0, 3'b000, 32'h200,   12'h002, 0,            1, 32'h80FF7F01, 0, 0, 16'h0200, 4'hF,    0, 32'hFFFFFFFF);
      tbl[3]  = mk(0, 3'b101, 32'h202,   12'h000, 0,            0, 32'h80FF7F01, 0, 0, 16'h0200, 4'hF,    0, 32'h000080FF);
      tbl[4]  = mk(0, 3'b001, 32'h202,   12'h000, 0,            2, 32'h80FF7F01, 1, 0, 16'h0200, 4'hF,    0, 32'hFFFF80FF);
      tbl[5]  = mk(0, 3'b100, 32'h203,   12'h000, 0,            0, 32'h80FF7F01, 0, 0, 16'h0200, 4'hF,    0, 32'h00000080);
      tbl[6]  = mk(0, 3'b010, 32'h102,   12'h000, 0,            0, 0,            0, 1, 16'h0,    4'h0,    0, 0);
      tbl[7]  = mk(1, 3'b100, 32'h100,   12'h000, 32'h1,        0, 0,            0, 2, 16'h0,    4'h0,    0, 0);
      tbl[8]  = mk(0, 3'b010, 32'h10000, 12'h000, 0,            0, 0,            0, 2, 16'h0,    4'h0,    0, 0);
      tbl[9]  = mk(0, 3'b010, 32'h4,     12'hFFC, 0,            3, 32'h12345678, 0, 0, 16'h0000, 4'hF,    0, 32'h12345678);
      tbl[10] = mk(0, 3'b010, 32'h300,   12'h000, 0,          999, 0,            4, 3, 16'h0300, 4'hF,    0, 0);
      tbl[11] = mk(1, 3'b001, 32'h302,   12'h000, 32'h1234BEEF, 0, 0,            0, 0, 16'h0300, 4'b1100, 32'hBEEFBEEF, 0);
      tbl[12] = mk(0, 3'b010, 32'h10002, 12'h000, 0,            0, 0,            0, 2, 16'h0,    4'h0,    0, 0);

      #3;
      chk("reset.req_ready", 32'(req_ready), 1);
      chk("reset.rsp_valid", 32'(rsp_valid), 0);
      chk("reset.mem_req", 32'(mem_req), 0);
      chk("reset.outs", {mem_wdata[23:0], mem_be, mem_we, rsp_fault, rsp_misaligned, 1'b0}, 0);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);

      for (int i = 0; i < 13; i++) run(tbl[i], $sformatf("vec%0d", i));

      // Abandon an access mid-REQ with an async reset.
      req_valid = 1; req_store = 0; req_funct3 = 3'b010; req_base = 32'h40; req_offset = 0; req_rd = 5'd7;
      @(posedge clk); #1;
      req_valid = 0;
      @(negedge clk);
      chk("rst_mid.mem_req_before", 32'(mem_req), 1);
      #2 rst_n = 0;
      #1;
      chk("rst_mid.mem_req", 32'(mem_req), 0);
      chk("rst_mid.req_ready", 32'(req_ready), 1);
      mem_ack = 1;
      @(negedge clk);
      mem_ack = 0;
      rst_n = 1;
      repeat (3) begin
         @(negedge clk);
         chk("rst_mid.no_rsp", 32'(rsp_valid), 0);
         chk("rst_mid.no_req", 32'(mem_req), 0);
      end

      for (int i = 0; i < 80; i++) begin
         rv.store = 1'($urandom);
         rv.f3    = 3'($urandom);
         rv.base  = ($urandom % 8 == 0) ? 32'($urandom) : 32'($urandom % 32'h10000);
         rv.off   = 12'($urandom);
         rv.wdata = $urandom;
         rv.rd    = 5'($urandom);
         rv.delay = ($urandom % 10 == 0) ? 20 : int'($urandom % 5);
         rv.rdata = $urandom;
         rv.hold  = int'($urandom % 3);
         rv = model(rv);
         run(rv, $sformatf("rnd%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
